seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_det_pkg.sv | 25 ++
 rtl/seq_sat_counter.sv | 25 ++
 rtl/seq_detect_param.sv | 95 +++++++++
 tb/tb_seq_detect_param.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and configuration record for the serial pattern detector.
// The record is sized for the largest supported pattern so every instance can share it.
package seq_det_pkg;

  localparam int MAX_LEN_LIMIT = 32;

  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  localparam int LEN_W = len_w(MAX_LEN_LIMIT);

  localparam int          DEF_MAX_LEN      = 8;
  localparam int          DEF_CNT_W        = 16;
  localparam int unsigned DEF_PATTERN_INIT = 32'b101;
  localparam int          DEF_LEN_INIT     = 3;
  localparam bit          DEF_OVERLAP_INIT = 1'b1;

  typedef struct packed {
    logic [MAX_LEN_LIMIT-1:0] pattern;
    logic [LEN_W-1:0]         len;
    logic                     overlap;
  } seq_cfg_t;

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a same-cycle increment.
module seq_sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == '1) return c;
    return c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with overlap control and a match counter.
// Only the low len bits of the history are compared; fill gates matches until len fresh bits arrive.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int          MAX_LEN     = DEF_MAX_LEN,
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned DEF_PATTERN = DEF_PATTERN_INIT,
  parameter int          DEF_LEN     = DEF_LEN_INIT,
  parameter bit          DEF_OVERLAP = DEF_OVERLAP_INIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_load,
  input  logic [MAX_LEN-1:0]         cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0]  cfg_len,
  input  logic                       cfg_overlap,
  input  logic                       x_valid,
  input  logic                       x,
  input  logic                       clr_cnt,
  output logic                       y,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int FW = len_w(MAX_LEN);

  seq_cfg_t           cfg_q;
  logic [MAX_LEN-1:0] hist;
  logic [FW-1:0]      fill;
  logic               y_p1;

  logic [MAX_LEN-1:0] hist_next;
  logic [FW-1:0]      fill_next;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] pat;
  logic               match_p0;
  logic               hit_p0;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l > LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  always_comb begin
    hist_next = {hist[MAX_LEN-2:0], x};
    fill_next = (fill == FW'(MAX_LEN)) ? fill : fill + FW'(1);
    pat       = cfg_q.pattern[MAX_LEN-1:0];
    mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < cfg_q.len);
    end
    match_p0 = (cfg_q.len != '0) &&
               (LEN_W'(fill_next) >= cfg_q.len) &&
               (((hist_next ^ pat) & mask) == '0);
    hit_p0   = x_valid && !cfg_load && match_p0;
  end

  // ---- stage p0 -> p1: history/fill update and registered match pulse ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q.pattern <= MAX_LEN_LIMIT'(DEF_PATTERN);
      cfg_q.len     <= clamp_len(LEN_W'(DEF_LEN));
      cfg_q.overlap <= DEF_OVERLAP;
      hist          <= '0;
      fill          <= '0;
      y_p1          <= 1'b0;
    end else if (cfg_load) begin
      cfg_q.pattern <= MAX_LEN_LIMIT'(cfg_pattern);
      cfg_q.len     <= clamp_len(LEN_W'(cfg_len));
      cfg_q.overlap <= cfg_overlap;
      fill          <= '0;
      y_p1          <= 1'b0;
    end else if (x_valid) begin
      hist <= hist_next;
      // Non-overlap mode restarts the fill so the next match needs len fresh bits.
      fill <= (match_p0 && !cfg_q.overlap) ? '0 : fill_next;
      y_p1 <= match_p0;
    end else begin
      y_p1 <= 1'b0;
    end
  end

  assign y = y_p1;

  seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit_p0),
    .clr (clr_cnt),
    .cnt (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param with a 2-bit match counter to reach saturation quickly.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       x_valid = 1'b0;
  logic       x = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       y;
  logic [1:0] match_cnt;

  int total = 0;
  int bad = 0;

  seq_detect_param #(
    .MAX_LEN (8),
    .CNT_W   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .x_valid     (x_valid),
    .x           (x),
    .clr_cnt     (clr_cnt),
    .y           (y),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    x_valid = 1'b1;
    x = b;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic idle();
    x_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    x_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                          input logic xv, input logic xb, input logic clr);
    cfg_load = 1'b1;
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = ov;
    x_valid = xv;
    x = xb;
    clr_cnt = clr;
    tick();
    cfg_load = 1'b0;
    x_valid = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x_valid = 1'b1;
    x = 1'b1;
    clr_cnt = 1'b0;
    tick();
    tick();
    x_valid = 1'b0;
    total++;
    if (y !== 1'b0) begin bad++; $display("FAIL reset_y actual=%b required=0", y); end
    total++;
    if (match_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt actual=%0d required=0", match_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_default_overlap();
    logic [4:0] bits;
    logic [4:0] exp_y;
    bits  = 5'b10101;
    exp_y = 5'b00101;
    for (int i = 4; i >= 0; i--) begin
      send(bits[i]);
      total++;
      if (y !== exp_y[i]) begin
        bad++; $display("FAIL default_y bit%0d actual=%b required=%b", 4 - i, y, exp_y[i]);
      end
    end
    total++;
    if (match_cnt !== 2'd2) begin bad++; $display("FAIL default_cnt actual=%0d required=2", match_cnt); end
    idle();
    total++;
    if (y !== 1'b0) begin bad++; $display("FAIL default_idle_y actual=%b required=0", y); end
  endtask

  task automatic test_nonoverlap();
    logic [4:0] bits;
    logic [4:0] exp_y;
    bits  = 5'b10101;
    exp_y = 5'b00100;
    load_cfg(8'b101, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 4; i >= 0; i--) begin
      send(bits[i]);
      total++;
      if (y !== exp_y[i]) begin
        bad++; $display("FAIL nonovl_y bit%0d actual=%b required=%b", 4 - i, y, exp_y[i]);
      end
    end
    total++;
    if (match_cnt !== 2'd1) begin bad++; $display("FAIL nonovl_cnt actual=%0d required=1", match_cnt); end
  endtask

  task automatic test_gapped_maxlen();
    logic [7:0] p;
    p = 8'b11010011;
    load_cfg(p, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      send(p[i]);
      total++;
      if (y !== (i == 0)) begin
        bad++; $display("FAIL gapped_y valid_bit%0d actual=%b required=%b", 7 - i, y, (i == 0));
      end
      idle();
      total++;
      if (y !== 1'b0) begin bad++; $display("FAIL gapped_gap_y after_bit%0d actual=%b required=0", 7 - i, y); end
    end
    total++;
    if (match_cnt !== 2'd1) begin bad++; $display("FAIL gapped_cnt actual=%0d required=1", match_cnt); end
  endtask

  task automatic test_reset_mid();
    pulse_rst();
    send(1'b1);
    send(1'b0);
    pulse_rst();
    total++;
    if (y !== 1'b0) begin bad++; $display("FAIL midrst_y_after_rst actual=%b required=0", y); end
    send(1'b1);
    total++;
    if (y !== 1'b0) begin bad++; $display("FAIL midrst_y_stale actual=%b required=0", y); end
    send(1'b0);
    total++;
    if (y !== 1'b0) begin bad++; $display("FAIL midrst_y_b2 actual=%b required=0", y); end
    send(1'b1);
    total++;
    if (y !== 1'b1) begin bad++; $display("FAIL midrst_y_fresh actual=%b required=1", y); end
  endtask

  task automatic test_cnt_sat();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    pulse_rst();
    send(1'b1);
    for (int k = 0; k < 5; k++) begin
      send(1'b0);
      send(1'b1);
      total++;
      if (y !== 1'b1) begin bad++; $display("FAIL sat_y match%0d actual=%b required=1", k + 1, y); end
      total++;
      if (match_cnt !== exp_cnt[k]) begin
        bad++; $display("FAIL sat_cnt match%0d actual=%0d required=%0d", k + 1, match_cnt, exp_cnt[k]);
      end
    end
    send(1'b0);
    clr_cnt = 1'b1;
    send(1'b1);
    clr_cnt = 1'b0;
    total++;
    if (y !== 1'b1) begin bad++; $display("FAIL clr_match_y actual=%b required=1", y); end
    total++;
    if (match_cnt !== 2'd0) begin bad++; $display("FAIL clr_wins_cnt actual=%0d required=0", match_cnt); end
  endtask

  task automatic test_cfg_bounds();
    logic [3:0] exp_y;
    logic [7:0] p;
    int         ones;
    // A bit presented with cfg_load must not count toward the next match.
    load_cfg(8'b101, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_y = 4'b0001;
    send(1'b0);
    total++;
    if (y !== exp_y[3]) begin bad++; $display("FAIL load_discard_y b1 actual=%b required=%b", y, exp_y[3]); end
    send(1'b1);
    total++;
    if (y !== exp_y[2]) begin bad++; $display("FAIL load_discard_y b2 actual=%b required=%b", y, exp_y[2]); end
    send(1'b0);
    total++;
    if (y !== exp_y[1]) begin bad++; $display("FAIL load_discard_y b3 actual=%b required=%b", y, exp_y[1]); end
    send(1'b1);
    total++;
    if (y !== exp_y[0]) begin bad++; $display("FAIL load_discard_y b4 actual=%b required=%b", y, exp_y[0]); end

    load_cfg(8'b101, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    ones = 0;
    for (int i = 0; i < 100; i++) begin
      send(1'($urandom_range(0, 1)));
      if (y === 1'b1) ones++;
    end
    total++;
    if (ones != 0) begin bad++; $display("FAIL len0_pulses actual=%0d required=0", ones); end
    total++;
    if (match_cnt !== 2'd0) begin bad++; $display("FAIL len0_cnt actual=%0d required=0", match_cnt); end

    p = 8'b11010011;
    load_cfg(p, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      send(p[i]);
      total++;
      if (y !== (i == 0)) begin
        bad++; $display("FAIL clamp_y bit%0d actual=%b required=%b", 7 - i, y, (i == 0));
      end
    end

    load_cfg(8'b11110101, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    total++;
    if (y !== 1'b1) begin bad++; $display("FAIL upper_bits_ignored_y actual=%b required=1", y); end
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_nonoverlap();
    test_gapped_maxlen();
    test_reset_mid();
    test_cnt_sat();
    test_cfg_bounds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
